// File: rtl/apb_ram_slave_ws_pkg.sv
// Shared types for the APB4 RAM slave: FSM states, violation codes, log2 helper.
// Violation codes are one-hot so several can be reported in the same cycle.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int VIOL_W = 3;
    typedef logic [VIOL_W-1:0] viol_t;

    localparam viol_t VIOL_NONE      = 3'b000;
    localparam viol_t VIOL_NO_SETUP  = 3'b001;
    localparam viol_t VIOL_CHANGE    = 3'b010;
    localparam viol_t VIOL_PSEL_DROP = 3'b100;

    function automatic int clog2(input int value);
        int r = 0;
        int v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_ram_slave_ws_if.sv
// APB4 bus bundle for one slave slot; the master modport drives requests and the
// slave modport returns PRDATA/PREADY/PSLVERR.
interface apb_ram_slave_ws_if #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [AWIDTH-1:0]     PADDR;
    logic [DWIDTH-1:0]     PWDATA;
    logic [DWIDTH/8-1:0]   PSTRB;
    logic [DWIDTH-1:0]     PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_ram_slave_ws_checker.sv
// APB protocol watcher: combinational violation code each cycle, registered sticky flag
// and saturating 8-bit count (one count per violating cycle). Never stalls the bus.
module apb_protocol_checker
    import apb_slave_pkg::*;
#(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                psel_i,
    input  logic                penable_i,
    input  logic                pwrite_i,
    input  logic [AWIDTH-1:0]   paddr_i,
    input  logic [DWIDTH-1:0]   pwdata_i,
    input  logic [DWIDTH/8-1:0] pstrb_i,
    input  logic                pready_i,
    output viol_t               viol_o,
    output logic                prot_err_o,
    output logic [7:0]          err_cnt_o
);

    logic                in_xfer_q, in_xfer_d;
    logic [AWIDTH-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DWIDTH-1:0]   pwdata_q, pwdata_d;
    logic [DWIDTH/8-1:0] pstrb_q, pstrb_d;
    logic                prot_err_q, prot_err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic                changed;
    viol_t               viol;

    // Strobes only matter for writes, so a read may wiggle PSTRB freely.
    assign changed = (paddr_i != paddr_q) || (pwrite_i != pwrite_q) ||
                     (pwdata_i != pwdata_q) || (pwrite_q && (pstrb_i != pstrb_q));

    always_comb begin
        viol       = VIOL_NONE;
        in_xfer_d  = in_xfer_q;
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        pstrb_d    = pstrb_q;
        prot_err_d = prot_err_q;
        err_cnt_d  = err_cnt_q;

        if (psel_i && penable_i && !in_xfer_q) viol = viol | VIOL_NO_SETUP;
        if (in_xfer_q && psel_i && changed)    viol = viol | VIOL_CHANGE;
        if (in_xfer_q && !psel_i)              viol = viol | VIOL_PSEL_DROP;

        if (psel_i && !penable_i && !in_xfer_q) begin
            in_xfer_d = 1'b1;
            paddr_d   = paddr_i;
            pwrite_d  = pwrite_i;
            pwdata_d  = pwdata_i;
            pstrb_d   = pstrb_i;
        end else if (in_xfer_q && (!psel_i || pready_i)) begin
            in_xfer_d = 1'b0;
        end

        if (viol != VIOL_NONE) begin
            prot_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_xfer_q  <= 1'b0;
            paddr_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
            prot_err_q <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            in_xfer_q  <= in_xfer_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            pstrb_q    <= pstrb_d;
            prot_err_q <= prot_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign viol_o     = viol;
    assign prot_err_o = prot_err_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: rtl/apb_ram_slave_ws.sv
// APB4 RAM slave, PREADY in access cycle WAIT_CNT+1 (sampled at setup), registered outputs.
// Byte-lane writes commit on the PREADY cycle; out-of-range words answer PSLVERR.
module apb_ram_slave_ws
    import apb_slave_pkg::*;
#(
    parameter int ID     = 0,
    parameter int DEBUG  = 0,
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 256,
    parameter int WWIDTH = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_ram_slave_ws_if.slave apb,
    input  logic [WWIDTH-1:0] WAIT_CNT,
    output logic              PROT_ERR,
    output logic [7:0]        ERR_CNT
);

    localparam int NB   = DWIDTH / 8;
    localparam int LSB  = clog2(NB);
    localparam int IDXW = AWIDTH - LSB;
    localparam int MAW  = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

    if (!(DWIDTH == 8 || DWIDTH == 16 || DWIDTH == 32) || ID < 0 || DEBUG < 0 || IDXW < MAW)
    begin : g_param_err
        $error("apb_ram_slave_ws: unsupported parameter set");
    end

    apb_state_e          state_q, state_d, cur_state;
    logic [WWIDTH-1:0]   cnt_q, cnt_d;
    logic [MAW-1:0]      addr_q, addr_d;
    logic                write_q, write_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]       strb_q, strb_d;
    logic                oor_q, oor_d;
    logic [DWIDTH-1:0]   prdata_q, prdata_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic                arm, we;
    logic                arm_oor, arm_write;
    logic [IDXW-1:0]     in_idx;
    logic                in_oor;
    logic [MAW-1:0]      rd_addr;
    viol_t               viol;

    logic [DWIDTH-1:0]   mem_q [DEPTH];

    assign in_idx = apb.PADDR[AWIDTH-1:LSB];
    assign in_oor = 32'(in_idx) >= 32'(DEPTH);

    // The setup cycle is recognised combinationally so a zero-wait read can
    // register its data in time for the first access cycle.
    always_comb begin
        cur_state = state_q;
        if (state_q == IDLE && apb.PSEL && !apb.PENABLE) cur_state = SETUP;
    end

    assign arm_oor   = (cur_state == SETUP) ? in_oor : oor_q;
    assign arm_write = (cur_state == SETUP) ? apb.PWRITE : write_q;
    assign rd_addr   = (cur_state == SETUP) ? in_idx[MAW-1:0] : addr_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        oor_d     = oor_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        arm       = 1'b0;
        we        = 1'b0;

        case (cur_state)
            SETUP: begin
                addr_d  = in_idx[MAW-1:0];
                write_d = apb.PWRITE;
                wdata_d = apb.PWDATA;
                strb_d  = apb.PSTRB;
                oor_d   = in_oor;
                cnt_d   = WAIT_CNT;
                arm     = (WAIT_CNT == '0);
                state_d = ACCESS;
            end
            ACCESS: begin
                if ((viol & VIOL_PSEL_DROP) != VIOL_NONE) begin
                    state_d = IDLE;
                end else if (pready_q) begin
                    we      = write_q && !oor_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = (cnt_q == '0) ? '0 : cnt_q - WWIDTH'(1);
                    arm   = (cnt_q <= WWIDTH'(1));
                end
            end
            default: ;
        endcase

        if (arm) begin
            pready_d  = 1'b1;
            pslverr_d = arm_oor;
            if (!arm_write) prdata_d = arm_oor ? '0 : mem_q[rd_addr];
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            oor_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            oor_q     <= oor_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Storage is deliberately left uninitialised across reset.
    always_ff @(posedge PCLK) begin
        if (!PRESET && we) begin
            for (int i = 0; i < NB; i++) begin
                if (strb_q[i]) mem_q[addr_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
            end
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;

    apb_protocol_checker #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_checker (
        .clk_i      (PCLK),
        .rst_i      (PRESET),
        .psel_i     (apb.PSEL),
        .penable_i  (apb.PENABLE),
        .pwrite_i   (apb.PWRITE),
        .paddr_i    (apb.PADDR),
        .pwdata_i   (apb.PWDATA),
        .pstrb_i    (apb.PSTRB),
        .pready_i   (pready_q),
        .viol_o     (viol),
        .prot_err_o (PROT_ERR),
        .err_cnt_o  (ERR_CNT)
    );

endmodule

// File: tb/tb_apb_ram_slave_ws.sv
// Directed bench for apb_ram_slave_ws: hand-computed vectors, one checking task.
module tb_apb_ram_slave_ws;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic [3:0] WAIT_CNT;
    logic       PROT_ERR;
    logic [7:0] ERR_CNT;

    int n_vec  = 0;
    int n_miss = 0;

    apb_ram_slave_ws_if #(.AWIDTH(12), .DWIDTH(32)) bus ();

    apb_ram_slave_ws #(
        .ID(0), .DEBUG(0), .AWIDTH(12), .DWIDTH(32), .DEPTH(256), .WWIDTH(4)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .apb      (bus),
        .WAIT_CNT (WAIT_CNT),
        .PROT_ERR (PROT_ERR),
        .ERR_CNT  (ERR_CNT)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Setup then access; returns at the negedge of the PREADY cycle with PSEL still high.
    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [3:0] mid_wait, input logic glitch,
                        output logic [31:0] rdata, output logic slverr, output int acc);
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
        bus.PADDR = addr; bus.PWDATA = wdata; bus.PSTRB = strb;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        WAIT_CNT = mid_wait;
        if (glitch) bus.PADDR = addr ^ 12'h004;
        acc = 0;
        while (1) begin
            @(negedge PCLK);
            acc++;
            if (bus.PREADY) break;
            if (acc >= 64) begin
                chk("timeout_pready", {31'b0, bus.PREADY}, 32'd1);
                break;
            end
            @(posedge PCLK); #1;
            bus.PADDR = addr;
        end
        rdata  = bus.PRDATA;
        slverr = bus.PSLVERR;
    endtask

    task automatic bus_idle();
        @(posedge PCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [11:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int exp_acc, input logic exp_err);
        logic [31:0] rd; logic err; int acc;
        xfer(1'b1, addr, data, strb, WAIT_CNT, 1'b0, rd, err, acc);
        chk({tag, "_lat"}, acc, exp_acc);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp_data,
                          input int exp_acc, input logic exp_err);
        logic [31:0] rd; logic err; int acc;
        xfer(1'b0, addr, 32'h0, 4'hF, WAIT_CNT, 1'b0, rd, err, acc);
        chk({tag, "_lat"}, acc, exp_acc);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        chk({tag, "_data"}, rd, exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd; logic err; int acc;
        PRESET = 1'b1; WAIT_CNT = 4'd0;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0; bus.PSTRB = '0;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        chk("rst_prdata", bus.PRDATA, 32'h0);
        chk("rst_pready", {31'b0, bus.PREADY}, 32'd0);
        chk("rst_pslverr", {31'b0, bus.PSLVERR}, 32'd0);
        chk("rst_prot_err", {31'b0, PROT_ERR}, 32'd0);
        chk("rst_err_cnt", {24'b0, ERR_CNT}, 32'd0);

        // Zero-wait write/read, low address bits ignored
        WAIT_CNT = 4'd0;
        wr_chk("t1_wr", 12'h010, 32'hA5A5_1234, 4'hF, 1, 1'b0); bus_idle();
        rd_chk("t1_rd", 12'h010, 32'hA5A5_1234, 1, 1'b0); bus_idle();
        rd_chk("t1_lowbits", 12'h013, 32'hA5A5_1234, 1, 1'b0); bus_idle();

        // Three wait states; WAIT_CNT changed mid-transfer must not alter timing
        WAIT_CNT = 4'd3;
        rd_chk("t2_ws3", 12'h010, 32'hA5A5_1234, 4, 1'b0); bus_idle();
        xfer(1'b0, 12'h010, 32'h0, 4'hF, 4'd0, 1'b0, rd, err, acc);
        chk("t2_midchg_lat", acc, 32'd4);
        chk("t2_midchg_data", rd, 32'hA5A5_1234);
        bus_idle();
        @(negedge PCLK);
        chk("t2_prdata_hold", bus.PRDATA, 32'hA5A5_1234);

        // Byte-lane strobes
        WAIT_CNT = 4'd1;
        wr_chk("t3_base", 12'h020, 32'h1122_3344, 4'hF, 2, 1'b0); bus_idle();
        wr_chk("t3_strb", 12'h020, 32'hFFFF_FFFF, 4'b0101, 2, 1'b0); bus_idle();
        rd_chk("t3_rd", 12'h020, 32'h11FF_33FF, 2, 1'b0); bus_idle();

        // Out of range: 0x400 is word 256, must not alias word 0
        WAIT_CNT = 4'd0;
        wr_chk("t4_w0", 12'h000, 32'h0BAD_F00D, 4'hF, 1, 1'b0); bus_idle();
        wr_chk("t4_oor_wr", 12'h400, 32'hDEAD_BEEF, 4'hF, 1, 1'b1); bus_idle();
        rd_chk("t4_oor_rd", 12'h400, 32'h0, 1, 1'b1); bus_idle();
        rd_chk("t4_ram0", 12'h000, 32'h0BAD_F00D, 1, 1'b0); bus_idle();
        wr_chk("t4_top_wr", 12'h3FC, 32'h600D_CAFE, 4'hF, 1, 1'b0); bus_idle();
        rd_chk("t4_top_rd", 12'h3FC, 32'h600D_CAFE, 1, 1'b0); bus_idle();

        // Back-to-back with PSEL held high
        wr_chk("t5_b1", 12'h100, 32'h0000_1111, 4'hF, 1, 1'b0);
        wr_chk("t5_b2", 12'h104, 32'h0000_2222, 4'hF, 1, 1'b0);
        rd_chk("t5_b3", 12'h100, 32'h0000_1111, 1, 1'b0);
        rd_chk("t5_b4", 12'h104, 32'h0000_2222, 1, 1'b0);
        chk("t5_b2b_err_cnt", {24'b0, ERR_CNT}, 32'd0);
        chk("t5_b2b_prot_err", {31'b0, PROT_ERR}, 32'd0);
        bus_idle();

        // PADDR changes for one wait cycle
        WAIT_CNT = 4'd2;
        xfer(1'b1, 12'h108, 32'h0000_0003, 4'hF, 4'd2, 1'b1, rd, err, acc);
        chk("t5_glitch_lat", acc, 32'd3);
        chk("t5_glitch_err_cnt", {24'b0, ERR_CNT}, 32'd1);
        chk("t5_glitch_prot_err", {31'b0, PROT_ERR}, 32'd1);
        bus_idle();

        // PSEL dropped while waiting: transfer abandoned, no write
        WAIT_CNT = 4'd0;
        wr_chk("t5_pre", 12'h10C, 32'h0000_0077, 4'hF, 1, 1'b0); bus_idle();
        WAIT_CNT = 4'd3;
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = 12'h10C; bus.PWDATA = 32'h0000_0055; bus.PSTRB = 4'hF;
        @(posedge PCLK); #1 bus.PENABLE = 1'b1;
        @(posedge PCLK); #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        @(negedge PCLK);
        chk("t5_drop_pready", {31'b0, bus.PREADY}, 32'd0);
        @(negedge PCLK);
        chk("t5_drop_err_cnt", {24'b0, ERR_CNT}, 32'd2);
        WAIT_CNT = 4'd0;
        rd_chk("t5_drop_rd", 12'h10C, 32'h0000_0077, 1, 1'b0); bus_idle();

        // PENABLE without a preceding setup cycle
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = 12'h000;
        @(negedge PCLK);
        chk("t5_nosetup_pready", {31'b0, bus.PREADY}, 32'd0);
        bus_idle();
        @(negedge PCLK);
        chk("t5_nosetup_err_cnt", {24'b0, ERR_CNT}, 32'd3);

        // Reset in the middle of a 5-wait write
        wr_chk("t6_pre", 12'h200, 32'h1234_5678, 4'hF, 1, 1'b0); bus_idle();
        rd_chk("t6_pre_rd", 12'h200, 32'h1234_5678, 1, 1'b0); bus_idle();
        WAIT_CNT = 4'd5;
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = 12'h200; bus.PWDATA = 32'hFFFF_FFFF; bus.PSTRB = 4'hF;
        @(posedge PCLK); #1 bus.PENABLE = 1'b1;
        @(posedge PCLK); #1 PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        @(negedge PCLK);
        chk("t6_prdata", bus.PRDATA, 32'h0);
        chk("t6_pready", {31'b0, bus.PREADY}, 32'd0);
        chk("t6_pslverr", {31'b0, bus.PSLVERR}, 32'd0);
        chk("t6_prot_err", {31'b0, PROT_ERR}, 32'd0);
        chk("t6_err_cnt", {24'b0, ERR_CNT}, 32'd0);
        WAIT_CNT = 4'd0;
        rd_chk("t6_word", 12'h200, 32'h1234_5678, 1, 1'b0); bus_idle();
        chk("t6_err_cnt_after", {24'b0, ERR_CNT}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
